// File: rtl/menu_pkg.sv
// Shared definitions for the menu controller: page encodings, per-page item
// counts and keyboard bit positions.
package menu_pkg;

  typedef enum logic [2:0] {
    ST_MAIN       = 3'd0,
    ST_CAR_SELECT = 3'd1,
    ST_SETTINGS   = 3'd2,
    ST_CREDITS    = 3'd3,
    ST_START      = 3'd4
  } menu_state_e;

  localparam logic [2:0] ITEMS_MAIN       = 3'd3;
  localparam logic [2:0] ITEMS_CAR_SELECT = 3'd4;
  localparam logic [2:0] ITEMS_SETTINGS   = 3'd2;
  localparam logic [2:0] ITEMS_CREDITS    = 3'd1;
  localparam logic [2:0] ITEMS_START      = 3'd0;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_ENTER = 2;
  localparam int KEY_ESC   = 3;

  function automatic logic [2:0] item_count(menu_state_e s);
    logic [2:0] n;
    case (s)
      ST_MAIN:       n = ITEMS_MAIN;
      ST_CAR_SELECT: n = ITEMS_CAR_SELECT;
      ST_SETTINGS:   n = ITEMS_SETTINGS;
      ST_CREDITS:    n = ITEMS_CREDITS;
      ST_START:      n = ITEMS_START;
      default:       n = 3'd0;
    endcase
    return n;
  endfunction

  // Index of the last selectable item; pages with no items report 0.
  function automatic logic [1:0] last_item(menu_state_e s);
    logic [2:0] n;
    n = item_count(s);
    if (n == 3'd0) begin
      return 2'd0;
    end else begin
      return 2'(n - 3'd1);
    end
  endfunction

endpackage

// File: rtl/menu_key_debounce.sv
// Single-key debouncer: the accepted level follows the raw level only after
// the raw level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
// rise_o pulses for one cycle in the cycle the accepted level becomes 1.
module menu_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive disagreeing samples and flip the level on the last one.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = CW'(0);
    if (key_raw_i != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = key_raw_i;
        rise_d  = key_raw_i;
        cnt_d   = CW'(0);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = CW'(0);
    end
  end

  // Debounce state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= CW'(0);
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/menu_controller.sv
// Menu page/item controller with frame-aligned pointer outputs.
// Optional macro MENU_WRAP_EN: when defined, up/down wrap around at the
// first/last item; otherwise the item counter saturates.
module menu_controller
  import menu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int X_POINTER       = 250,
  parameter int Y_BASE          = 200,
  parameter int Y_STEP          = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  keyboard_in,
  input  logic        vblnk_in,
  output logic [2:0]  menu_state,
  output logic [1:0]  menu_counter,
  output logic [10:0] x_pointer,
  output logic [10:0] y_pointer,
  output logic [1:0]  car_sel,
  output logic        game_start
);

  logic [3:0]  key_level_s, key_rise_s, key_evt_s;
  menu_state_e state_q, state_d;
  logic [1:0]  counter_q, counter_d;
  logic [1:0]  car_sel_q, car_sel_d;
  logic        game_start_q, game_start_d;
  logic [1:0]  last_s;
  logic        vblnk_q, vblnk_rise_s;
  logic [10:0] y_calc_s;
  logic [2:0]  menu_state_q;
  logic [1:0]  menu_counter_q;
  logic [10:0] x_pointer_q, y_pointer_q;

  for (genvar k = 0; k < 4; k++) begin : g_key
    menu_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk       (clk),
      .rst       (rst),
      .key_raw_i (keyboard_in[k]),
      .level_o   (key_level_s[k]),
      .rise_o    (key_rise_s[k])
    );
  end

  // A rise pulse is only honoured while its accepted level is high.
  assign key_evt_s    = key_rise_s & key_level_s;
  assign last_s       = last_item(state_q);
  assign vblnk_rise_s = vblnk_in & ~vblnk_q;
  assign y_calc_s     = 11'(Y_BASE) + 11'(counter_q) * 11'(Y_STEP);

  // Next page/item from the single highest-priority key event this cycle.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    car_sel_d = car_sel_q;
    if (key_evt_s[KEY_ESC]) begin
      case (state_q)
        ST_CAR_SELECT, ST_SETTINGS, ST_CREDITS: begin
          state_d   = ST_MAIN;
          counter_d = 2'd0;
        end
        default: state_d = state_q;
      endcase
    end else if (key_evt_s[KEY_ENTER]) begin
      case (state_q)
        ST_MAIN: begin
          case (counter_q)
            2'd0:    state_d = ST_CAR_SELECT;
            2'd1:    state_d = ST_SETTINGS;
            2'd2:    state_d = ST_CREDITS;
            default: state_d = state_q;
          endcase
          counter_d = 2'd0;
        end
        ST_CAR_SELECT: begin
          state_d   = ST_START;
          car_sel_d = counter_q;
          counter_d = 2'd0;
        end
        ST_CREDITS: begin
          state_d   = ST_MAIN;
          counter_d = 2'd0;
        end
        default: state_d = state_q;
      endcase
    end else if (key_evt_s[KEY_UP]) begin
      if (counter_q == 2'd0) begin
`ifdef MENU_WRAP_EN
        counter_d = last_s;
`else
        counter_d = 2'd0;
`endif
      end else begin
        counter_d = counter_q - 2'd1;
      end
    end else if (key_evt_s[KEY_DOWN]) begin
      if (counter_q >= last_s) begin
`ifdef MENU_WRAP_EN
        counter_d = 2'd0;
`else
        counter_d = last_s;
`endif
      end else begin
        counter_d = counter_q + 2'd1;
      end
    end else begin
      state_d = state_q;
    end
    game_start_d = (state_d == ST_START);
  end

  // Internal page/item state and the unaligned car/game outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_MAIN;
      counter_q    <= 2'd0;
      car_sel_q    <= 2'd0;
      game_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      car_sel_q    <= car_sel_d;
      game_start_q <= game_start_d;
    end
  end

  // Shadow outputs refreshed only when vertical blanking begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q        <= 1'b0;
      menu_state_q   <= 3'd0;
      menu_counter_q <= 2'd0;
      x_pointer_q    <= 11'(X_POINTER);
      y_pointer_q    <= 11'(Y_BASE);
    end else begin
      vblnk_q <= vblnk_in;
      if (vblnk_rise_s) begin
        menu_state_q   <= state_q;
        menu_counter_q <= counter_q;
        x_pointer_q    <= 11'(X_POINTER);
        y_pointer_q    <= y_calc_s;
      end else begin
        menu_state_q   <= menu_state_q;
        menu_counter_q <= menu_counter_q;
        x_pointer_q    <= x_pointer_q;
        y_pointer_q    <= y_pointer_q;
      end
    end
  end

  assign menu_state   = menu_state_q;
  assign menu_counter = menu_counter_q;
  assign x_pointer    = x_pointer_q;
  assign y_pointer    = y_pointer_q;
  assign car_sel      = car_sel_q;
  assign game_start   = game_start_q;

endmodule

// File: tb/tb_menu_controller.sv
// Directed bench for menu_controller; expectations queued in a scoreboard and
// compared once the shadow outputs are refreshed.
module tb_menu_controller;

  localparam int DC = 4;
  localparam int XP = 250;
  localparam int YB = 200;
  localparam int YS = 100;

  localparam logic [3:0] K_UP    = 4'b0001;
  localparam logic [3:0] K_DOWN  = 4'b0010;
  localparam logic [3:0] K_ENTER = 4'b0100;
  localparam logic [3:0] K_ESC   = 4'b1000;

  typedef struct packed {
    logic [2:0]  st;
    logic [1:0]  cnt;
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  car;
    logic        gs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  keyboard_in;
  logic        vblnk_in;
  logic [2:0]  menu_state;
  logic [1:0]  menu_counter;
  logic [10:0] x_pointer, y_pointer;
  logic [1:0]  car_sel;
  logic        game_start;

  exp_t  exp_q[$];
  string tag_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  menu_controller #(
    .DEBOUNCE_CYCLES(DC), .X_POINTER(XP), .Y_BASE(YB), .Y_STEP(YS)
  ) dut (
    .clk(clk), .rst(rst), .keyboard_in(keyboard_in), .vblnk_in(vblnk_in),
    .menu_state(menu_state), .menu_counter(menu_counter),
    .x_pointer(x_pointer), .y_pointer(y_pointer),
    .car_sel(car_sel), .game_start(game_start)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask, input int hold);
    keyboard_in = mask;
    tick(hold);
    keyboard_in = 4'b0000;
    tick(8);
  endtask

  task automatic frame();
    vblnk_in = 1'b1;
    tick(2);
    vblnk_in = 1'b0;
    tick(2);
  endtask

  task automatic expect_out(input string tag, input int st, input int cnt,
                            input int car, input int gs);
    exp_t e;
    e.st  = 3'(st);
    e.cnt = 2'(cnt);
    e.x   = 11'(XP);
    e.y   = 11'(YB + cnt * YS);
    e.car = 2'(car);
    e.gs  = 1'(gs);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic cmp(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t  e;
    string t;
    tests_run++;
    assert (exp_q.size() != 0) else begin
      tests_failed++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      cmp({t, ".menu_state"},   int'(menu_state),   int'(e.st));
      cmp({t, ".menu_counter"}, int'(menu_counter), int'(e.cnt));
      cmp({t, ".x_pointer"},    int'(x_pointer),    int'(e.x));
      cmp({t, ".y_pointer"},    int'(y_pointer),    int'(e.y));
      cmp({t, ".car_sel"},      int'(car_sel),      int'(e.car));
      cmp({t, ".game_start"},   int'(game_start),   int'(e.gs));
    end
  endtask

  initial begin
    rst = 1'b1;
    keyboard_in = 4'b0000;
    vblnk_in = 1'b0;
    tick(3);
    expect_out("reset", 0, 0, 0, 0);
    check_out();
    rst = 1'b0;
    tick(2);

    // Too-short press is filtered.
    press(K_DOWN, 3);
    frame();
    expect_out("short_press", 0, 0, 0, 0);
    check_out();

    // Long press: one step, visible only after the next blanking rise.
    press(K_DOWN, 10);
    expect_out("pre_vblnk", 0, 0, 0, 0);
    check_out();
    frame();
    expect_out("down_once", 0, 1, 0, 0);
    check_out();

    press(K_UP, 10);
    frame();
    expect_out("up_to_0", 0, 0, 0, 0);
    check_out();

    // Up at item 0 of MAIN.
    press(K_UP, 10);
    frame();
`ifdef MENU_WRAP_EN
    expect_out("up_bound", 0, 2, 0, 0);
    check_out();
    press(K_DOWN, 10);
    frame();
`else
    expect_out("up_bound", 0, 0, 0, 0);
    check_out();
    frame();
`endif
    expect_out("main_item0", 0, 0, 0, 0);
    check_out();

    press(K_ENTER, 10);
    frame();
    expect_out("car_select", 1, 0, 0, 0);
    check_out();
    for (int i = 1; i <= 3; i++) begin
      press(K_DOWN, 10);
      frame();
      expect_out($sformatf("car_down%0d", i), 1, i, 0, 0);
      check_out();
    end

    // Entering START: car/game outputs are immediate, shadows still old.
    press(K_ENTER, 10);
    expect_out("start_unaligned", 1, 3, 3, 1);
    check_out();
    frame();
    expect_out("start_aligned", 4, 0, 3, 1);
    check_out();

    press(K_ESC, 10);
    frame();
    expect_out("start_ignores", 4, 0, 3, 1);
    check_out();

    // Reset coinciding with a blanking rise.
    vblnk_in = 1'b1;
    rst = 1'b1;
    tick(1);
    expect_out("rst_in_start", 0, 0, 0, 0);
    check_out();
    rst = 1'b0;
    vblnk_in = 1'b0;
    tick(2);
    frame();
    expect_out("post_rst_frame", 0, 0, 0, 0);
    check_out();

    // Escape beats enter in CAR_SELECT.
    press(K_ENTER, 10);
    press(K_DOWN, 10);
    press(K_ESC | K_ENTER, 10);
    frame();
    expect_out("esc_over_enter", 0, 0, 0, 0);
    check_out();

    // SETTINGS bound behaviour and return.
    press(K_DOWN, 10);
    press(K_ENTER, 10);
    frame();
    expect_out("settings", 2, 0, 0, 0);
    check_out();
    press(K_DOWN, 10);
    press(K_DOWN, 10);
    frame();
`ifdef MENU_WRAP_EN
    expect_out("settings_bound", 2, 0, 0, 0);
`else
    expect_out("settings_bound", 2, 1, 0, 0);
`endif
    check_out();
    press(K_ESC, 10);
    press(K_DOWN, 10);
    press(K_DOWN, 10);
    press(K_ENTER, 10);
    press(K_DOWN, 10);
    frame();
    expect_out("credits_single", 3, 0, 0, 0);
    check_out();
    press(K_ENTER, 10);
    frame();
    expect_out("credits_enter", 0, 0, 0, 0);
    check_out();

    // Escape in MAIN is ignored and swallows a simultaneous enter.
    press(K_DOWN, 10);
    press(K_ESC | K_ENTER, 10);
    frame();
    expect_out("esc_in_main", 0, 1, 0, 0);
    check_out();

    // Key held through reset produces one event afterwards.
    keyboard_in = K_DOWN;
    tick(2);
    rst = 1'b1;
    tick(2);
    expect_out("rst_mid_debounce", 0, 0, 0, 0);
    check_out();
    rst = 1'b0;
    tick(12);
    keyboard_in = 4'b0000;
    tick(8);
    frame();
    expect_out("held_after_rst", 0, 1, 0, 0);
    check_out();

    cmp("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/menu_controller.md
MENU_CONTROLLER -- requirements
Module: menu_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 65000: number of consecutive stable cycles a key level must hold before it is accepted.
REQ-002 Parameter X_POINTER, default 250: pointer x position, identical for all pages.
REQ-003 Parameter Y_BASE, default 200: pointer y position for item 0.
REQ-004 Parameter Y_STEP, default 100: pointer y increment per item.
REQ-005 clk  input  1  system/pixel clock; the block uses only this one clock.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 keyboard_in  input  4  raw key levels: [0] up, [1] down, [2] enter, [3] escape.
REQ-008 vblnk_in  input  1  vertical blanking from the timing chain.
REQ-009 menu_state  output  3  current page, frame-aligned.
REQ-010 menu_counter  output  2  selected item on the page, frame-aligned.
REQ-011 x_pointer  output  11  pointer x position, frame-aligned.
REQ-012 y_pointer  output  11  pointer y position, frame-aligned.
REQ-013 car_sel  output  2  chosen car, latched on entry to START.
REQ-014 game_start  output  1  level signal, high while the state is START.

Function
REQ-015 Each key SHALL be debounced independently; a debounced level changes only after the raw level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 A key event SHALL be the 0->1 edge of a debounced level; holding a key SHALL produce exactly one event.
REQ-017 At most one event SHALL be processed per cycle, with priority escape > enter > up > down; lower-priority events in the same cycle SHALL be discarded.
REQ-018 States and encodings: MAIN=0 (3 items), CAR_SELECT=1 (4 items), SETTINGS=2 (2 items), CREDITS=3 (1 item), START=4 (0 items).
REQ-019 Up SHALL decrement the item counter and down SHALL increment it; at the bounds, behaviour follows REQ-029.
REQ-020 MAIN + enter SHALL go to CAR_SELECT, SETTINGS or CREDITS for items 0, 1 and 2 respectively.
REQ-021 CAR_SELECT + enter SHALL go to START and latch car_sel = counter.
REQ-022 CREDITS + enter, or escape in CAR_SELECT, SETTINGS or CREDITS, SHALL go to MAIN.
REQ-023 Escape in MAIN, and every event in START, SHALL be ignored.
REQ-024 Every page change SHALL reset the counter to 0.
REQ-025 Internal state and counter SHALL update in the cycle after the event.
REQ-026 Pointer position: y = Y_BASE + counter*Y_STEP, computed in 11 bits; x = X_POINTER.
REQ-027 menu_state, menu_counter, x_pointer and y_pointer SHALL be shadow registers.
- Loaded from the internal values only on the cycle after a vblnk_in 0->1 edge.
- Never change during active video.
- Several events within one frame: only the latest internal value is presented.
REQ-028 game_start and car_sel SHALL be driven directly from internal state, without frame alignment.

Reset
REQ-029 (Bound behaviour, referenced by REQ-019.) Counter at the top or bottom item; see REQ-034.
REQ-030 On rst high at a clock edge, all outputs SHALL take these values on the next cycle: menu_state=0, menu_counter=0, x_pointer=X_POINTER, y_pointer=Y_BASE, car_sel=0, game_start=0.
REQ-031 On rst high, the debounced levels, debounce counters and vblnk edge register SHALL clear to 0.
REQ-032 A reset asserted mid-debounce or mid-frame SHALL discard any pending event and any pending shadow update.
REQ-033 After rst is released, a key already held SHALL generate one event once it has been stable for DEBOUNCE_CYCLES.

Configuration
REQ-034 Macro MENU_WRAP_EN controls counter behaviour at the bounds.
- Defined: up at item 0 wraps to the last item; down at the last item wraps to 0.
- Undefined: the counter saturates at both bounds.
- Single-item pages hold 0 in both cases.

Structure
REQ-035 A shared package menu_pkg SHALL hold the state encodings, the per-page item counts and the key bit indices.
REQ-036 One sub-module, menu_key_debounce, SHALL be instantiated four times; it outputs the debounced level and a one-cycle rise pulse.

Verification (DEBOUNCE_CYCLES=4 in the bench)
REQ-037 Down held 3 cycles, then released -> no counter change.
REQ-038 Down held 10 cycles -> internal counter 0->1 exactly once; menu_counter and y_pointer (300) update only after the next vblnk_in rise.
REQ-039 Enter at MAIN item 0, down x3, enter -> with wrap: counter sequence 1,2,3, then START with car_sel=3 and game_start=1; without wrap, the same sequence ends at 3.
REQ-040 Up at MAIN item 0 -> counter 2 with MENU_WRAP_EN defined, 0 without it.
REQ-041 Escape and enter pressed in the same cycle in CAR_SELECT -> state MAIN, counter 0.
REQ-042 rst asserted in START with shadow update pending -> all outputs at reset values next cycle; no stale value appears after the next vblnk_in rise.
